// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_WRITE,
    ST_RUN,
    ST_ERR
  } loader_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into a 32-bit word; word_valid_o marks the final byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          clear_i,
  input  logic                          in_valid_i,
  input  logic [7:0]                    in_data_i,
  output logic [8*BYTES_PER_WORD-1:0]   word_o,
  output logic                          word_valid_o,
  output logic [IDX_W-1:0]              byte_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  // Only the first three bytes are stored; the last one is merged straight from the input.
  logic [8*(BYTES_PER_WORD-1)-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]                idx_q, idx_d;

  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (in_valid_i) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        buf_d[idx_q*8 +: 8] = in_data_i;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      buf_q <= '0;
      idx_q <= '0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
    end
  end

  assign word_o       = {in_data_i, buf_q};
  assign word_valid_o = in_valid_i && (idx_q == LAST_IDX);
  assign byte_idx_o   = idx_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then enables the core.
// Stream bytes move on s_valid && s_ready (s_ready is the only combinational output).
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned       MAX_WORDS = 128,
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [31:0]       wdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              err,
  output logic [15:0]       word_cnt,
  output loader_state_e     state_o
);

  loader_state_e           state_q, state_d;
  logic [8*HDR_BYTES-1:0]  hdr_q, hdr_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    wen_q, en_q, busy_q, err_q;

  logic                    xfer;
  logic                    start_ok;
  logic [15:0]             n_full;
  logic [31:0]             pk_word;
  logic                    pk_word_valid;
  logic [IDX_W-1:0]        pk_idx;

  assign s_ready  = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA);
  assign xfer     = s_valid && s_ready;
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_ERR));
  assign n_full   = {s_data, hdr_q[7:0]};

  byte_packer u_packer (
    .clk          (clk),
    .arst_n       (arst_n),
    .clear_i      (start_ok),
    .in_valid_i   (xfer && (state_q == ST_DATA)),
    .in_data_i    (s_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid),
    .byte_idx_o   (pk_idx)
  );

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR0;
          cnt_d   = '0;
        end
      end
      ST_HDR0: begin
        if (xfer) begin
          hdr_d[7:0] = s_data;
          state_d    = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (xfer) begin
          hdr_d[15:8] = s_data;
          if (n_full == 16'd0)                  state_d = ST_RUN;
          else if (32'(n_full) > MAX_WORDS)     state_d = ST_ERR;
          else                                  state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Address and data are captured here so they are stable through the WRITE cycle.
        if (pk_word_valid) begin
          state_d = ST_WRITE;
          wdata_d = pk_word;
          addr_d  = BASE_ADDR + (ADDR_W'(cnt_q) << 2);
        end
      end
      ST_WRITE: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_d == hdr_q) ? ST_RUN : ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= (state_d == ST_WRITE);
      en_q    <= (state_d == ST_RUN);
      busy_q  <= (state_d == ST_HDR0) || (state_d == ST_HDR1) ||
                 (state_d == ST_DATA) || (state_d == ST_WRITE);
      err_q   <= (state_d == ST_ERR);
    end
  end

  assign addr_ext   = addr_q;
  assign wen_ext    = wen_q;
  assign ren_ext    = 1'b0;
  assign wdata_ext  = wdata_q;
  assign cpu_enable = en_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign word_cnt   = cnt_q;
  assign state_o    = state_q;

endmodule
